// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OpMultu = 2'b00,
        OpMult  = 2'b01,
        OpDivu  = 2'b10,
        OpDiv   = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } muldiv_state_e;

    function automatic logic is_signed_op(input muldiv_op_e op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic is_div_op(input muldiv_op_e op);
        return (op == OpDivu) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation.
module muldiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: sign-magnitude operands, one bit per cycle, sign fixup at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    muldiv_state_e          state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       mag_b_q, mag_b_d;
    logic                   is_div_q, is_div_d;
    logic                   res_neg_q, res_neg_d;
    logic                   rem_neg_q, rem_neg_d;
    logic                   dbz_q, dbz_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dbz_out_q, dbz_out_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;

    muldiv_op_e             op_e;
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH:0]         rem_shift;
    logic                   div_ok;
    logic [WIDTH-1:0]       div_diff;
    logic [2*WIDTH-1:0]     div_next;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    assign op_e  = muldiv_op_e'(op);
    assign a_neg = is_signed_op(op_e) & a[WIDTH-1];
    assign b_neg = is_signed_op(op_e) & b[WIDTH-1];

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(a_neg), .x(a), .y(mag_a));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(b_neg), .x(b), .y(mag_b));

    // Shift-add: multiplier bits leave at the bottom while the product fills from the top.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: remainder in the upper half, dividend/quotient in the lower half.
    assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ok    = rem_shift >= {1'b0, mag_b_q};
    assign div_diff  = rem_shift[WIDTH-1:0] - mag_b_q;
    assign div_next  = div_ok ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .neg (res_neg_q),
        .x   (acc_q),
        .y   (prod_fix)
    );
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .neg (res_neg_q),
        .x   (acc_q[WIDTH-1:0]),
        .y   (quo_fix)
    );
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .neg (rem_neg_q),
        .x   (acc_q[2*WIDTH-1:WIDTH]),
        .y   (rem_fix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_b_d   = mag_b_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCalc;
                    cnt_d     = CntW'(WIDTH);
                    acc_d     = {{WIDTH{1'b0}}, mag_a};
                    mag_b_d   = mag_b;
                    is_div_d  = is_div_op(op_e);
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    dbz_d     = is_div_op(op_e) && (b == '0);
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d    = 1'b1;
                    dbz_out_d = dbz_q;
                    if (is_div_q) begin
                        // With b == 0 the remainder is |a|, so rem_fix restores the original a.
                        hi_d = rem_fix;
                        lo_d = dbz_q ? '1 : quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_b_q   <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_b_q   <= mag_b_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit at WIDTH 32 and 8 against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  op_tb;
    logic [31:0] a_tb, b_tb;
    logic        start32, flush32, busy32, done32, dbz32;
    logic [31:0] hi32, lo32;
    logic        start8, flush8, busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_hi32, last_lo32;
    logic [31:0] got_hi, got_lo;
    logic        got_dbz;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start32),
        .op          (op_tb),
        .a           (a_tb),
        .b           (b_tb),
        .flush       (flush32),
        .busy        (busy32),
        .done        (done32),
        .hi          (hi32),
        .lo          (lo32),
        .div_by_zero (dbz32)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .op          (op_tb),
        .a           (a_tb[7:0]),
        .b           (b_tb[7:0]),
        .flush       (flush8),
        .busy        (busy8),
        .done        (done8),
        .hi          (hi8),
        .lo          (lo8),
        .div_by_zero (dbz8)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Plain-integer reference: results taken as w-bit slices of exact arithmetic.
    function automatic void ref_model(input int w, input logic [1:0] op_v,
                                      input logic [31:0] a_v, input logic [31:0] b_v,
                                      output logic [31:0] hi_e, output logic [31:0] lo_e,
                                      output logic dbz_e);
        longint          one  = 1;
        longint          mask = (one <<< w) - 1;
        longint          ua   = longint'({32'b0, a_v}) & mask;
        longint          ub   = longint'({32'b0, b_v}) & mask;
        longint          sa   = ua[w-1] ? ua - (one <<< w) : ua;
        longint          sb   = ub[w-1] ? ub - (one <<< w) : ub;
        longint unsigned pu;
        longint          q, r;
        dbz_e = 1'b0;
        if (op_v[1] == 1'b0) begin
            if (op_v[0]) pu = longint'(sa * sb);
            else         pu = longint'(ua) * longint'(ub);
            hi_e = 32'((pu >> w) & mask);
            lo_e = 32'(pu & mask);
        end else if (ub == 0) begin
            dbz_e = 1'b1;
            hi_e  = 32'(ua);
            lo_e  = 32'(mask);
        end else begin
            if (op_v[0]) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            hi_e = 32'(r & mask);
            lo_e = 32'(q & mask);
        end
    endfunction

    function automatic logic [31:0] pick(input int w);
        int          s = int'($urandom_range(0, 5));
        logic [31:0] v;
        case (s)
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hffff_ffff;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7fff_ffff;
            default: v = $urandom;
        endcase
        if (w == 8) begin
            if (s == 3 || s == 4) v = v >> 24;
            v = v & 32'hff;
        end
        return v;
    endfunction

    // Called at a negedge; leaves the bench at the negedge where done is seen.
    task automatic run_op(input bit w8, input logic [1:0] op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input bit with_flush);
        int          w        = w8 ? 8 : 32;
        int          idx      = 1;
        int          busy_cnt = 0;
        logic [31:0] ehi, elo;
        logic        edbz;
        ref_model(w, op_v, a_v, b_v, ehi, elo, edbz);
        op_tb = op_v;
        a_tb  = a_v;
        b_tb  = b_v;
        if (w8) begin
            start8 = 1'b1;
            flush8 = with_flush;
        end else begin
            start32 = 1'b1;
            flush32 = with_flush;
        end
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
        flush8  = 1'b0;
        flush32 = 1'b0;
        check_val("no_done_after_start", 64'({w8 ? done8 : done32, w8 ? dbz8 : dbz32}), 64'(0));
        while (!(w8 ? done8 : done32) && idx < 100) begin
            if (w8 ? busy8 : busy32) busy_cnt++;
            @(negedge clk);
            idx++;
        end
        got_hi  = w8 ? {24'b0, hi8} : hi32;
        got_lo  = w8 ? {24'b0, lo8} : lo32;
        got_dbz = w8 ? dbz8 : dbz32;
        check_val("latency", 64'(idx - 1), 64'(w + 1));
        check_val("busy_cycles", 64'(busy_cnt), 64'(w + 1));
        check_val("idle_at_done", 64'(w8 ? busy8 : busy32), 64'(0));
        check_val("hi", 64'(got_hi), 64'(ehi));
        check_val("lo", 64'(got_lo), 64'(elo));
        check_val("div_by_zero", 64'(got_dbz), 64'(edbz));
        if (!w8) begin
            last_hi32 = ehi;
            last_lo32 = elo;
        end
    endtask

    task automatic run_dir(input bit w8, input logic [1:0] op_v, input logic [31:0] a_v,
                           input logic [31:0] b_v, input logic [31:0] hi_c,
                           input logic [31:0] lo_c, input logic dbz_c);
        run_op(w8, op_v, a_v, b_v, 1'b0);
        check_val("dir_hi", 64'(got_hi), 64'(hi_c));
        check_val("dir_lo", 64'(got_lo), 64'(lo_c));
        check_val("dir_dbz", 64'(got_dbz), 64'(dbz_c));
    endtask

    initial begin
        logic [31:0] ehi, elo;
        logic        edbz;
        int          n_done;
        logic [31:0] cap_hi, cap_lo;

        rst_n   = 1'b1;
        start32 = 1'b0;
        flush32 = 1'b0;
        start8  = 1'b0;
        flush8  = 1'b0;
        op_tb   = 2'b00;
        a_tb    = '0;
        b_tb    = '0;
        #2 rst_n = 1'b0;
        #1;
        check_val("reset_ctrl32", 64'({busy32, done32, dbz32}), 64'(0));
        check_val("reset_data32", {hi32, lo32}, 64'(0));
        check_val("reset_all8", 64'({busy8, done8, dbz8, hi8, lo8}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_dir(1'b0, 2'b00, 32'd5, 32'd7, 32'h0, 32'd35, 1'b0);
        run_dir(1'b0, 2'b01, 32'hffff_ffff, 32'd3, 32'hffff_ffff, 32'hffff_fffd, 1'b0);
        run_dir(1'b0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_dir(1'b0, 2'b11, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 1'b0);
        run_dir(1'b0, 2'b10, 32'hffff_ffff, 32'd16, 32'hf, 32'h0fff_ffff, 1'b0);
        run_dir(1'b0, 2'b10, 32'd7, 32'd0, 32'd7, 32'hffff_ffff, 1'b1);
        run_dir(1'b0, 2'b11, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 1'b0);
        run_dir(1'b0, 2'b11, 32'hffff_fff9, 32'd0, 32'hffff_fff9, 32'hffff_ffff, 1'b1);

        // start and flush together in IDLE: the op must still run.
        @(negedge clk);
        run_op(1'b0, 2'b01, 32'hffff_fffe, 32'd9, 1'b1);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op(1'b0, 2'($urandom_range(0, 3)), pick(32), pick(32), 1'b0);
        end

        // Second start mid-op is dropped, not queued.
        @(negedge clk);
        ref_model(32, 2'b00, 32'd1234, 32'd5678, ehi, elo, edbz);
        op_tb   = 2'b00;
        a_tb    = 32'd1234;
        b_tb    = 32'd5678;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        op_tb   = 2'b10;
        a_tb    = 32'd100;
        b_tb    = 32'd3;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        n_done  = 0;
        cap_hi  = '0;
        cap_lo  = '0;
        for (int i = 0; i < 80; i++) begin
            if (done32) begin
                n_done++;
                cap_hi = hi32;
                cap_lo = lo32;
            end
            @(negedge clk);
        end
        check_val("ignored_start_dones", 64'(n_done), 64'(1));
        check_val("ignored_start_hi", 64'(cap_hi), 64'(ehi));
        check_val("ignored_start_lo", 64'(cap_lo), 64'(elo));
        check_val("ignored_start_idle", 64'(busy32), 64'(0));
        last_hi32 = ehi;
        last_lo32 = elo;

        // Flush around CALC cycle 10.
        op_tb   = 2'b11;
        a_tb    = 32'hdead_beef;
        b_tb    = 32'd77;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        check_val("flush_busy", 64'(busy32), 64'(0));
        n_done = 0;
        for (int i = 0; i < 45; i++) begin
            if (done32) n_done++;
            @(negedge clk);
        end
        check_val("flush_no_done", 64'(n_done), 64'(0));
        check_val("flush_hi_kept", 64'(hi32), 64'(last_hi32));
        check_val("flush_lo_kept", 64'(lo32), 64'(last_lo32));

        // Reset mid-op clears everything at once and leaves no pending done.
        op_tb   = 2'b01;
        a_tb    = 32'h1234_5678;
        b_tb    = 32'h9abc_def0;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midop_reset_ctrl", 64'({busy32, done32, dbz32}), 64'(0));
        check_val("midop_reset_data", {hi32, lo32}, 64'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done32) n_done++;
            @(negedge clk);
        end
        check_val("reset_no_done", 64'(n_done), 64'(0));

        run_dir(1'b1, 2'b01, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0);
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op(1'b1, 2'($urandom_range(0, 3)), pick(8), pick(8), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
